iter_alu: RTL

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu_pkg.sv | 26 ++
 rtl/iter_alu_muldiv.sv | 97 +++++++++
 rtl/iter_alu.sv | 130 +++++++++++++
 3 files changed

// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative ALU: opcode encodings, FSM states and
// default widths. Imported by iter_alu and iter_alu_muldiv.
package iter_alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned OPW_DEFAULT  = 4;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/iter_alu_muldiv.sv
// Iterative multiply / unsigned divide engine. One bit per cycle for exactly
// XLEN cycles after start: shift-add multiply (low XLEN bits) and restoring
// division. `done` is high during the final step, and `res` then carries the
// value produced by that step so the caller can register it on the same edge.
module iter_alu_muldiv
    import iter_alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned OPW  = OPW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int unsigned CW = $clog2(XLEN);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic            is_mul_q;
    logic            is_rem_q;
    // mul: acc = partial product, x = multiplier, y = multiplicand
    // div: rem = partial remainder, x = dividend/quotient, y = divisor
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] x_q, x_d;
    logic [XLEN-1:0] y_q, y_d;

    logic [XLEN:0]   shifted;
    logic            ge;

    // One iteration step of whichever operation is loaded.
    always_comb begin
        shifted = {rem_q, x_q[XLEN-1]};
        ge      = (shifted >= {1'b0, y_q});
        acc_d   = acc_q + (x_q[0] ? y_q : '0);
        // Remainder always fits XLEN bits, so the subtraction may drop the top bit.
        rem_d   = ge ? (shifted[XLEN-1:0] - y_q) : shifted[XLEN-1:0];
        if (is_mul_q) begin
            x_d = x_q >> 1;
            y_d = y_q << 1;
        end else begin
            x_d = {x_q[XLEN-2:0], ge};
            y_d = y_q;
        end
    end

    // Final-step result select and completion flag.
    always_comb begin
        done = busy_q && (cnt_q == CW'(XLEN - 1));
        if (is_mul_q) begin
            res = acc_d;
        end else if (is_rem_q) begin
            res = rem_d;
        end else begin
            res = x_d;
        end
    end

    // Operand load on start, then one step per cycle while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            is_rem_q <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_mul_q <= (op == OPW'(OP_MUL));
            is_rem_q <= (op == OPW'(OP_REMU));
            acc_q    <= '0;
            rem_q    <= '0;
            x_q      <= (op == OPW'(OP_MUL)) ? b : a;
            y_q      <= (op == OPW'(OP_MUL)) ? a : b;
        end else if (busy_q) begin
            cnt_q <= cnt_q + CW'(1);
            acc_q <= acc_d;
            rem_q <= rem_d;
            x_q   <= x_d;
            y_q   <= y_d;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU top: single-cycle logic/arith ops plus, when the macro
// ITER_ALU_MULDIV_EN is defined, XLEN-cycle MUL/DIVU/REMU via
// iter_alu_muldiv. Without the macro those opcodes decode as unknown (0).
// Valid/ready handshake on both sides; one operation in flight at a time.
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned OPW  = OPW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int unsigned SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic [XLEN-1:0] alu_res;

`ifdef ITER_ALU_MULDIV_EN
    logic            is_iter;
    logic            md_start;
    logic            md_done;
    logic [XLEN-1:0] md_res;

    assign is_iter = (op == OPW'(OP_MUL)) || (op == OPW'(OP_DIVU)) || (op == OPW'(OP_REMU));

    iter_alu_muldiv #(
        .XLEN (XLEN),
        .OPW  (OPW)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .op    (op),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .res   (md_res)
    );
`endif

    // Single-cycle datapath on the live request inputs.
    always_comb begin
        alu_res = '0;
        case (op)
            OPW'(OP_AND): alu_res = a & b;
            OPW'(OP_OR):  alu_res = a | b;
            OPW'(OP_ADD): alu_res = a + b;
            OPW'(OP_XOR): alu_res = a ^ b;
            OPW'(OP_SLL): alu_res = a << b[SHW-1:0];
            OPW'(OP_SRL): alu_res = a >> b[SHW-1:0];
            OPW'(OP_SUB): alu_res = a - b;
            OPW'(OP_SLT): alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default:      alu_res = '0;
        endcase
    end

    // Next-state, result capture and engine start.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef ITER_ALU_MULDIV_EN
        md_start = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
`ifdef ITER_ALU_MULDIV_EN
                    if (is_iter) begin
                        md_start = 1'b1;
                        state_d  = StCalc;
                    end else
`endif
                    begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = StDone;
                    end
                end
            end
`ifdef ITER_ALU_MULDIV_EN
            StCalc: begin
                if (md_done) begin
                    result_d = md_res;
                    zero_d   = (md_res == '0);
                    state_d  = StDone;
                end
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered result; reset clears any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule
